vs_single_port_ram_arbiter: RTL and testbench

Shares one vs_single_port_ram (1 read/write port, registered read address, 1-cycle read latency) between NUM_REQ requesters. Uses round-robin arbitration with an optional lock for back-to-back bursts. Each requester has a valid/ready request channel and a per-requester response strobe for read data. Sits between the sparse-matrix engines and a shared scratch RAM.

---
 rtl/vs_ram_arb_pkg.sv | 17 +
 rtl/vs_rr_arbiter.sv | 38 +++
 rtl/vs_single_port_ram.sv | 26 ++
 rtl/vs_single_port_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_vs_single_port_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vs_ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Included by the arbiter top and its round-robin sub-block.
package vs_ram_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  function automatic int unsigned rr_next(
    input int unsigned ptr,
    input int unsigned n
  );
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/vs_rr_arbiter.sv
// Circular first-valid search starting at pointer.
// With mask_en only the pointer slot itself may win.
module vs_rr_arbiter
  import vs_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               mask_en,
  input  logic [IW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, pointer} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!found && req[idx] && (!mask_en || i == 0)) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/vs_single_port_ram.sv
// Single-port RAM, registered read address, write-first.
// Read data appears the cycle after the address is presented.
module vs_single_port_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clock) begin
    if (write_enable) mem_q[addr] <= in_data;
    addr_q <= addr;
  end

  assign out_data = mem_q[addr_q];

endmodule

// File: rtl/vs_single_port_ram_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port RAM.
// Read responses are strobed to the requester one cycle after grant.
module vs_single_port_ram_arbiter
  import vs_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int IW         = $clog2(NUM_REQ)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             busy
);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic                  locked;
  logic [IW-1:0]         arb_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         gidx;
  logic                  hs, g_write, g_lock;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_out;

  assign locked  = (state_q == ARB_LOCKED);
  assign arb_ptr = locked ? owner_q : ptr_q;

  vs_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req       (req_valid),
    .mask_en   (locked),
    .pointer   (arb_ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign hs      = |grant;
  assign g_write = req_write[gidx];
  assign g_lock  = req_lock[gidx];
  assign ram_we  = hs & g_write;
  // Hold the last address when idle so the RAM read port stays quiet
  assign ram_addr = hs ? addr_a[gidx] : addr_q;

  vs_single_port_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock        (clock),
    .write_enable (ram_we),
    .addr         (ram_addr),
    .in_data      (wdata_a[gidx]),
    .out_data     (ram_out)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = ram_addr;
    rsp_valid_d = (hs && !g_write) ? grant : '0;
    rsp_data_d  = (|rsp_valid_q) ? ram_out : rsp_data_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (hs) begin
          if (g_lock) begin
            state_d = ARB_LOCKED;
            owner_d = gidx;
          end else begin
            ptr_d = IW'(rr_next(32'(gidx), 32'(NUM_REQ)));
          end
        end
      end
      ARB_LOCKED: begin
        if (!req_valid[owner_q] || (hs && !g_lock)) begin
          state_d = ARB_IDLE;
          ptr_d   = IW'(rr_next(32'(owner_q), 32'(NUM_REQ)));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      addr_q      <= addr_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = (|rsp_valid_q) ? ram_out : rsp_data_q;
  assign busy      = locked;

endmodule

// File: tb/tb_vs_single_port_ram_arbiter.sv
// Bench for the RAM arbiter: reference model plus directed vectors.
// Model compared every cycle; literal expectations pin key points.
module tb_vs_single_port_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_write = '0;
  logic [N-1:0]      req_lock  = '0;
  logic [N*AW-1:0]   req_addr  = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  vs_single_port_ram_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules and a sparse memory image
  int         m_ptr    = 0;
  bit         m_locked = 1'b0;
  int         m_owner  = 0;
  int         m_rsp    = -1;
  logic [7:0] m_rsp_data = '0;
  logic [7:0] m_mem [int];
  int         mg;
  int         ma;

  function automatic int exp_grant();
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ptr = 0; m_locked = 1'b0; m_owner = 0;
      m_rsp = -1; m_rsp_data = '0;
    end else begin
      mg = exp_grant();
      m_rsp = -1;
      if (mg >= 0) begin
        ma = int'(req_addr[mg*AW +: AW]);
        if (req_write[mg]) begin
          m_mem[ma] = req_wdata[mg*DW +: DW];
        end else begin
          m_rsp = mg;
          m_rsp_data = m_mem.exists(ma) ? m_mem[ma] : 8'h00;
        end
      end
      if (m_locked) begin
        if (!req_valid[m_owner] || (mg == m_owner && !req_lock[m_owner])) begin
          m_locked = 1'b0;
          m_ptr = (m_owner + 1) % N;
        end
      end else if (mg >= 0) begin
        if (req_lock[mg]) begin
          m_locked = 1'b1;
          m_owner = mg;
        end else begin
          m_ptr = (mg + 1) % N;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      mg = exp_grant();
      check("m_ready", 32'(req_ready), (mg >= 0) ? (32'd1 << mg) : 32'd0);
      check("m_rsp_valid", 32'(rsp_valid),
            (m_rsp >= 0) ? (32'd1 << m_rsp) : 32'd0);
      check("m_rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      check("m_busy", 32'(busy), 32'(m_locked));
    end
  end

  task automatic clr();
    req_valid = '0; req_write = '0; req_lock = '0;
  endtask

  task automatic set_req(input int i, input bit wr, input bit lk,
                         input int addr, input int data);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_lock[i]  = lk;
    req_addr[i*AW +: AW]  = AW'(addr);
    req_wdata[i*DW +: DW] = DW'(data);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step();
    reset = 1'b0;

    // Writes then reads by requester 0
    for (int i = 0; i < 10; i++) begin
      clr(); set_req(0, 1'b1, 1'b0, i, i); step();
    end
    for (int i = 0; i < 10; i++) begin
      clr(); set_req(0, 1'b0, 1'b0, i, 0);
      @(negedge clock);
      if (i > 0) begin
        check("t1_valid", 32'(rsp_valid), 32'h1);
        check("t1_data", 32'(rsp_data), 32'(i - 1));
      end
      step();
    end
    clr();
    @(negedge clock);
    check("t1_valid_last", 32'(rsp_valid), 32'h1);
    check("t1_data_last", 32'(rsp_data), 32'd9);
    step();

    // Four readers of addr 5; pointer sits at 1
    for (int k = 0; k < 8; k++) begin
      clr();
      for (int r = 0; r < N; r++) set_req(r, 1'b0, 1'b0, 5, 0);
      @(negedge clock);
      check("t2_grant", 32'(req_ready), 32'd1 << ((1 + k) % 4));
      if (k > 0) begin
        check("t2_rsp", 32'(rsp_valid), 32'd1 << (k % 4));
        check("t2_data", 32'(rsp_data), 32'd5);
      end
      step();
    end
    clr(); step();

    // Move pointer to 2, then requester 2 locks a 3-write burst
    clr(); set_req(1, 1'b1, 1'b0, 100, 8'h11); step();
    for (int b = 0; b < 3; b++) begin
      clr();
      set_req(0, 1'b0, 1'b0, 5, 0);
      set_req(1, 1'b0, 1'b0, 5, 0);
      set_req(3, 1'b0, 1'b0, 5, 0);
      set_req(2, 1'b1, (b < 2), 20 + b, 8'h20 + b);
      @(negedge clock);
      check("t3_grant", 32'(req_ready), 32'h4);
      check("t3_busy", 32'(busy), (b > 0) ? 32'd1 : 32'd0);
      step();
    end
    clr();
    set_req(0, 1'b0, 1'b0, 5, 0);
    set_req(1, 1'b0, 1'b0, 5, 0);
    set_req(3, 1'b0, 1'b0, 5, 0);
    @(negedge clock);
    check("t3_after", 32'(req_ready), 32'h8);
    check("t3_unbusy", 32'(busy), 32'h0);
    step();
    clr(); step();

    // Read-after-write across requesters
    clr(); set_req(1, 1'b1, 1'b0, 3, 8'hA5); step();
    clr(); set_req(0, 1'b0, 1'b0, 3, 0); step();
    clr();
    @(negedge clock);
    check("t4_valid", 32'(rsp_valid), 32'h1);
    check("t4_data", 32'(rsp_data), 32'hA5);
    step();

    // Wraparound from pointer 3
    clr(); set_req(2, 1'b0, 1'b0, 5, 0); step();
    clr(); set_req(0, 1'b0, 1'b0, 5, 0); set_req(3, 1'b0, 1'b0, 5, 0);
    @(negedge clock);
    check("t5_grant3", 32'(req_ready), 32'h8);
    step();
    @(negedge clock);
    check("t5_grant0", 32'(req_ready), 32'h1);
    step();
    clr(); step();

    // Reset between a locked read and its response
    clr(); set_req(1, 1'b0, 1'b0, 5, 0); step();
    clr(); set_req(3, 1'b0, 1'b1, 5, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    clr();
    @(negedge clock);
    check("t6_rsp_drop", 32'(rsp_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    step();
    reset = 1'b0;
    set_req(1, 1'b0, 1'b0, 5, 0); set_req(3, 1'b0, 1'b0, 5, 0);
    @(negedge clock);
    check("t6_grant", 32'(req_ready), 32'h2);
    step();
    clr();
    @(negedge clock);
    check("t6_rsp", 32'(rsp_valid), 32'h2);
    check("t6_data", 32'(rsp_data), 32'h5);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
